// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destination registers after ID and
// decides per cycle whether to stall the front end or forward a later-stage result.
module hazard_scoreboard #(
   parameter int AW       = 3,
   parameter int DEPTH    = 3,
   parameter int FWD_EN   = 1,
   parameter int ZERO_REG = 0,
   parameter int SW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs1,
   input  logic [AW-1:0] id_rs2,
   input  logic          id_rs1_used,
   input  logic          id_rs2_used,
   input  logic [AW-1:0] id_rd,
   input  logic          id_wr_en,
   input  logic          id_is_load,
   input  logic          flush,
   input  logic          cnt_clr,
   output logic          pc_en,
   output logic          if_id_en,
   output logic          bubble,
   output logic [SW-1:0] fwd1_sel,
   output logic [SW-1:0] fwd2_sel,
   output logic [15:0]   stall_count
);

   logic [DEPTH-1:0]         ent_valid;
   logic [DEPTH-1:0]         ent_wr_en;
   logic [DEPTH-1:0]         ent_load;
   logic [DEPTH-1:0][AW-1:0] ent_rd;
   logic [15:0]              stall_cnt;

   logic          hit1, hit2;
   logic [SW-1:0] idx1, idx2;
   logic          zero1, zero2;
   logic          active;
   logic          load_use;
   logic          stall;

   // Scan oldest to youngest so the youngest matching entry overwrites the result.
   always_comb begin
      hit1  = 1'b0;
      hit2  = 1'b0;
      idx1  = '0;
      idx2  = '0;
      zero1 = (ZERO_REG != 0) && (id_rs1 == '0);
      zero2 = (ZERO_REG != 0) && (id_rs2 == '0);
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (id_rs1_used && !zero1 && ent_valid[k] && ent_wr_en[k] && (ent_rd[k] == id_rs1)) begin
            hit1 = 1'b1;
            idx1 = SW'(k);
         end
         if (id_rs2_used && !zero2 && ent_valid[k] && ent_wr_en[k] && (ent_rd[k] == id_rs2)) begin
            hit2 = 1'b1;
            idx2 = SW'(k);
         end
      end
   end

   always_comb begin
      active   = id_valid && !flush;
      load_use = ent_load[0] && ((hit1 && (idx1 == '0)) || (hit2 && (idx2 == '0)));
      if (FWD_EN != 0) begin
         stall = active && load_use;
      end else begin
         stall = active && (hit1 || hit2);
      end
      fwd1_sel = '0;
      fwd2_sel = '0;
      if ((FWD_EN != 0) && active && !stall) begin
         if (hit1) fwd1_sel = idx1 + SW'(1);
         if (hit2) fwd2_sel = idx2 + SW'(1);
      end
      pc_en    = !stall;
      if_id_en = !stall;
      bubble   = stall;
   end

   // A stalled or flushed ID instruction enters EX as an invalid entry (the bubble).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_valid <= '0;
         ent_wr_en <= '0;
         ent_load  <= '0;
         ent_rd    <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            ent_valid[i] <= ent_valid[i-1];
            ent_wr_en[i] <= ent_wr_en[i-1];
            ent_load[i]  <= ent_load[i-1];
            ent_rd[i]    <= ent_rd[i-1];
         end
         ent_valid[0] <= id_valid && !stall && !flush;
         ent_wr_en[0] <= id_wr_en;
         ent_load[0]  <= id_is_load;
         ent_rd[0]    <= id_rd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, stall-only and zero-register
// instances share one ID stream; each scenario resets and checks one instance.
module tb_hazard_scoreboard;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [2:0] id_rs1, id_rs2, id_rd;
   logic       id_rs1_used, id_rs2_used;
   logic       id_wr_en, id_is_load;
   logic       flush, cnt_clr;

   logic        f_pc_en, f_if_id_en, f_bubble;
   logic [1:0]  f_fwd1, f_fwd2;
   logic [15:0] f_cnt;
   logic        s_pc_en, s_if_id_en, s_bubble;
   logic [1:0]  s_fwd1, s_fwd2;
   logic [15:0] s_cnt;
   logic        z_pc_en, z_if_id_en, z_bubble;
   logic [1:0]  z_fwd1, z_fwd2;
   logic [15:0] z_cnt;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard #(.AW(3), .DEPTH(3), .FWD_EN(1), .ZERO_REG(0)) dut_f (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush), .cnt_clr(cnt_clr),
      .pc_en(f_pc_en), .if_id_en(f_if_id_en), .bubble(f_bubble),
      .fwd1_sel(f_fwd1), .fwd2_sel(f_fwd2), .stall_count(f_cnt));

   hazard_scoreboard #(.AW(3), .DEPTH(3), .FWD_EN(0), .ZERO_REG(0)) dut_s (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush), .cnt_clr(cnt_clr),
      .pc_en(s_pc_en), .if_id_en(s_if_id_en), .bubble(s_bubble),
      .fwd1_sel(s_fwd1), .fwd2_sel(s_fwd2), .stall_count(s_cnt));

   hazard_scoreboard #(.AW(3), .DEPTH(3), .FWD_EN(1), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush), .cnt_clr(cnt_clr),
      .pc_en(z_pc_en), .if_id_en(z_if_id_en), .bubble(z_bubble),
      .fwd1_sel(z_fwd1), .fwd2_sel(z_fwd2), .stall_count(z_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      id_valid    = 1'b0;
      id_rs1      = '0;
      id_rs2      = '0;
      id_rs1_used = 1'b0;
      id_rs2_used = 1'b0;
      id_rd       = '0;
      id_wr_en    = 1'b0;
      id_is_load  = 1'b0;
      flush       = 1'b0;
      cnt_clr     = 1'b0;
      #1;
   endtask

   task automatic issue(input logic [2:0] rs1, input logic u1, input logic [2:0] rs2,
                        input logic u2, input logic [2:0] rd, input logic we, input logic ld);
      id_valid    = 1'b1;
      id_rs1      = rs1;
      id_rs1_used = u1;
      id_rs2      = rs2;
      id_rs2_used = u2;
      id_rd       = rd;
      id_wr_en    = we;
      id_is_load  = ld;
      flush       = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      go_idle();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      go_idle();
      rst = 1'b0;
      #2;
      if (f_pc_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_pc_en got %b want 1", f_pc_en); end
      checks++;
      if (f_if_id_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_if_id_en got %b want 1", f_if_id_en); end
      checks++;
      if (f_bubble !== 1'b0) begin errors++; $display("[TB] FAIL reset_bubble got %b want 0", f_bubble); end
      checks++;
      if (f_fwd1 !== 2'd0 || f_fwd2 !== 2'd0) begin errors++; $display("[TB] FAIL reset_fwd got %0d/%0d want 0/0", f_fwd1, f_fwd2); end
      checks++;
      if (f_cnt !== 16'd0 || s_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %h/%h want 0", f_cnt, s_cnt); end
      checks++;
      if (s_pc_en !== 1'b1 || z_pc_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_pc_en_others got %b/%b want 1", s_pc_en, z_pc_en); end
      checks++;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_alu_forward();
      do_reset();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
      tick();
      issue(3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
      if (f_fwd1 !== 2'd1) begin errors++; $display("[TB] FAIL alu_fwd1_ex got %0d want 1", f_fwd1); end
      checks++;
      if (f_pc_en !== 1'b1 || f_bubble !== 1'b0) begin errors++; $display("[TB] FAIL alu_no_stall got pc_en=%b bubble=%b want 1/0", f_pc_en, f_bubble); end
      checks++;
      tick();
      issue(3'd3, 1'b1, 3'd6, 1'b1, 3'd7, 1'b0, 1'b0);
      if (f_fwd1 !== 2'd2 || f_fwd2 !== 2'd1) begin errors++; $display("[TB] FAIL alu_fwd_mem got %0d/%0d want 2/1", f_fwd1, f_fwd2); end
      checks++;
      tick();
      issue(3'd3, 1'b1, 3'd6, 1'b1, 3'd1, 1'b0, 1'b0);
      if (f_fwd1 !== 2'd3 || f_fwd2 !== 2'd2) begin errors++; $display("[TB] FAIL alu_fwd_wb got %0d/%0d want 3/2", f_fwd1, f_fwd2); end
      checks++;
      tick();
      issue(3'd7, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0);
      if (f_fwd1 !== 2'd0 || f_fwd2 !== 2'd3) begin errors++; $display("[TB] FAIL alu_no_wr_en got %0d/%0d want 0/3", f_fwd1, f_fwd2); end
      checks++;
      tick();
      go_idle();
   endtask

   task automatic test_load_use();
      do_reset();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
      tick();
      issue(3'd0, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0);
      if (f_pc_en !== 1'b0 || f_if_id_en !== 1'b0 || f_bubble !== 1'b1) begin
         errors++; $display("[TB] FAIL load_use_stall got pc_en=%b if_id_en=%b bubble=%b want 0/0/1", f_pc_en, f_if_id_en, f_bubble);
      end
      checks++;
      if (f_fwd2 !== 2'd0 || f_cnt !== 16'd0) begin errors++; $display("[TB] FAIL load_use_pre got fwd2=%0d cnt=%0d want 0/0", f_fwd2, f_cnt); end
      checks++;
      tick();
      if (f_cnt !== 16'd1) begin errors++; $display("[TB] FAIL load_use_count got %0d want 1", f_cnt); end
      checks++;
      if (f_pc_en !== 1'b1 || f_fwd2 !== 2'd2) begin errors++; $display("[TB] FAIL load_use_release got pc_en=%b fwd2=%0d want 1/2", f_pc_en, f_fwd2); end
      checks++;
      tick();
      go_idle();
      if (f_cnt !== 16'd1) begin errors++; $display("[TB] FAIL load_use_count_hold got %0d want 1", f_cnt); end
      checks++;
   endtask

   task automatic test_stall_only();
      do_reset();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
      tick();
      issue(3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         if (s_pc_en !== 1'b0 || s_bubble !== 1'b1 || s_fwd1 !== 2'd0) begin
            errors++; $display("[TB] FAIL stall_only_cycle%0d got pc_en=%b bubble=%b fwd1=%0d want 0/1/0", c, s_pc_en, s_bubble, s_fwd1);
         end
         checks++;
         tick();
      end
      if (s_pc_en !== 1'b1 || s_fwd1 !== 2'd0 || s_fwd2 !== 2'd0) begin
         errors++; $display("[TB] FAIL stall_only_done got pc_en=%b fwd=%0d/%0d want 1/0/0", s_pc_en, s_fwd1, s_fwd2);
      end
      checks++;
      if (s_cnt !== 16'd3) begin errors++; $display("[TB] FAIL stall_only_count got %0d want 3", s_cnt); end
      checks++;
      tick();
      go_idle();
   endtask

   task automatic test_youngest();
      do_reset();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
      tick();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
      tick();
      issue(3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      if (f_fwd1 !== 2'd1 || z_fwd1 !== 2'd1) begin errors++; $display("[TB] FAIL youngest_wins got %0d/%0d want 1/1", f_fwd1, z_fwd1); end
      checks++;
      tick();
      do_reset();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
      tick();
      issue(3'd0, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
      if (z_fwd1 !== 2'd0 || z_pc_en !== 1'b1) begin errors++; $display("[TB] FAIL zero_reg got fwd1=%0d pc_en=%b want 0/1", z_fwd1, z_pc_en); end
      checks++;
      if (f_pc_en !== 1'b0) begin errors++; $display("[TB] FAIL r0_tracked got pc_en=%b want 0", f_pc_en); end
      checks++;
      tick();
      go_idle();
   endtask

   task automatic test_flush();
      do_reset();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
      tick();
      issue(3'd2, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      if (f_pc_en !== 1'b1 || f_bubble !== 1'b0 || f_fwd1 !== 2'd0) begin
         errors++; $display("[TB] FAIL flush_priority got pc_en=%b bubble=%b fwd1=%0d want 1/0/0", f_pc_en, f_bubble, f_fwd1);
      end
      checks++;
      tick();
      issue(3'd3, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0);
      if (f_fwd1 !== 2'd0 || f_fwd2 !== 2'd2 || f_pc_en !== 1'b1) begin
         errors++; $display("[TB] FAIL flush_no_insert got fwd=%0d/%0d pc_en=%b want 0/2/1", f_fwd1, f_fwd2, f_pc_en);
      end
      checks++;
      if (f_cnt !== 16'd0) begin errors++; $display("[TB] FAIL flush_count got %0d want 0", f_cnt); end
      checks++;
      tick();
      go_idle();
   endtask

   task automatic test_saturation();
      do_reset();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
      tick();
      issue(3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      dut_s.stall_cnt = 16'hFFFE;
      tick();
      if (s_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_reach got %h want ffff", s_cnt); end
      checks++;
      tick();
      if (s_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold got %h want ffff", s_cnt); end
      checks++;
      if (s_pc_en !== 1'b0) begin errors++; $display("[TB] FAIL sat_still_stall got pc_en=%b want 0", s_pc_en); end
      checks++;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      if (s_cnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_priority got %h want 0", s_cnt); end
      checks++;
      tick();
      go_idle();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
      tick();
      issue(3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      if (s_pc_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_stall_pre got pc_en=%b want 0", s_pc_en); end
      checks++;
      tick();
      #1;
      rst = 1'b0;
      #1;
      if (s_pc_en !== 1'b1 || s_if_id_en !== 1'b1 || s_bubble !== 1'b0 || s_cnt !== 16'd0) begin
         errors++; $display("[TB] FAIL async_reset got pc_en=%b if_id_en=%b bubble=%b cnt=%0d want 1/1/0/0", s_pc_en, s_if_id_en, s_bubble, s_cnt);
      end
      checks++;
      #2;
      rst = 1'b1;
      #1;
      if (s_pc_en !== 1'b1 || s_fwd1 !== 2'd0) begin errors++; $display("[TB] FAIL post_reset_reader got pc_en=%b fwd1=%0d want 1/0", s_pc_en, s_fwd1); end
      checks++;
      tick();
      if (s_cnt !== 16'd0) begin errors++; $display("[TB] FAIL post_reset_count got %0d want 0", s_cnt); end
      checks++;
      go_idle();
   endtask

   initial begin
      rst = 1'b1;
      go_idle();
      test_reset();
      test_alu_forward();
      test_load_use();
      test_stall_only();
      test_youngest();
      test_flush();
      test_saturation();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
